// File: rtl/mem_sys_ctrl_if.sv
// Command, serial-load, memory and bit-stream signals of the mem_sys sequencer.
// The controller uses the slave modport; the host/memory side uses master.
interface mem_sys_ctrl_if #(
    parameter int XAW = 10,
    parameter int WAW = 20
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_bank_x;
    logic [1:0]           cmd_bank_w;
    logic [XAW-1:0]       cmd_len_in;
    logic [WAW-XAW-1:0]   cmd_len_out;
    logic                 ld_valid;
    logic                 ld_ready;
    logic                 ld_data;
    logic                 we_x;
    logic                 we_w;
    logic                 data_in;
    logic [XAW-1:0]       address_x;
    logic [WAW-1:0]       address_w;
    logic [1:0]           sel_x;
    logic [1:0]           sel_w;
    logic                 data_out_x;
    logic                 data_out_w;
    logic                 bit_valid;
    logic                 bit_x;
    logic                 bit_w;
    logic                 bit_first;
    logic                 bit_last;
    logic                 done;
    logic                 busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_bank_x, cmd_bank_w, cmd_len_in, cmd_len_out,
        input  ld_valid, ld_data, data_out_x, data_out_w,
        output cmd_ready, ld_ready, we_x, we_w, data_in, address_x, address_w,
        output sel_x, sel_w, bit_valid, bit_x, bit_w, bit_first, bit_last, done, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_bank_x, cmd_bank_w, cmd_len_in, cmd_len_out,
        output ld_valid, ld_data, data_out_x, data_out_w,
        input  cmd_ready, ld_ready, we_x, we_w, data_in, address_x, address_w,
        input  sel_x, sel_w, bit_valid, bit_x, bit_w, bit_first, bit_last, done, busy
    );
endinterface

// File: rtl/mem_sys_ctrl.sv
// Load/run sequencer for the bit-serial mem_sys; streams (x, w) bit pairs neuron-major.
// Optional MEM_SYS_CTRL_ABORT_EN adds an abort input that drops any operation back to IDLE.
module mem_sys_ctrl #(
    parameter int XAW = 10,
    parameter int WAW = 20
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MEM_SYS_CTRL_ABORT_EN
    input  logic abort,
`endif
    mem_sys_ctrl_if.slave bus
);
    localparam int OW = WAW - XAW;
    localparam logic [1:0] OP_LOAD_X = 2'b00;
    localparam logic [1:0] OP_LOAD_W = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, RUN, DRAIN} state_t;

    state_t          state, state_nx;
    logic [XAW-1:0]  i, len_in;
    logic [OW-1:0]   o, len_out;
    logic [WAW-1:0]  wa;
    logic [1:0]      sel_x, sel_w;
    logic            vld_q, first_q, last_q, done_q;
    logic            abrt, accept, loading, ld_fire, i_end, o_end, adv, load_final;

`ifdef MEM_SYS_CTRL_ABORT_EN
    assign abrt = abort && (state != IDLE);
`else
    assign abrt = 1'b0;
`endif

    assign accept     = (state == IDLE) && bus.cmd_valid;
    assign loading    = (state == LOAD_X) || (state == LOAD_W);
    assign ld_fire    = loading && bus.ld_valid && !abrt;
    assign i_end      = (i == len_in);
    assign o_end      = (o == len_out);
    assign adv        = ld_fire || ((state == RUN) && !abrt);
    assign load_final = ld_fire && i_end && ((state == LOAD_X) || o_end);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                case (bus.cmd_op)
                    OP_LOAD_X: state_nx = LOAD_X;
                    OP_LOAD_W: state_nx = LOAD_W;
                    OP_RUN:    state_nx = RUN;
                    default:   state_nx = IDLE;
                endcase
            end
            LOAD_X:  if (load_final) state_nx = IDLE;
            LOAD_W:  if (load_final) state_nx = IDLE;
            RUN:     if (i_end && o_end) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abrt) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i       <= '0;
            o       <= '0;
            wa      <= '0;
            len_in  <= '0;
            len_out <= '0;
            sel_x   <= '0;
            sel_w   <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            done_q  <= (accept && (bus.cmd_op == OP_NOP)) || load_final ||
                       ((state == DRAIN) && !abrt);
            // wa tracks o*(len_in+1)+i by plain increment alongside the nested i/o walk
            if (accept) begin
                i       <= '0;
                o       <= '0;
                wa      <= '0;
                len_in  <= bus.cmd_len_in;
                len_out <= bus.cmd_len_out;
                sel_x   <= bus.cmd_bank_x;
                sel_w   <= bus.cmd_bank_w;
            end else if (adv) begin
                i  <= i_end ? '0 : i + XAW'(1);
                wa <= wa + WAW'(1);
                if (i_end) o <= o_end ? '0 : o + OW'(1);
            end
            vld_q   <= (state == RUN) && !abrt;
            first_q <= (i == '0);
            last_q  <= i_end;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.ld_ready  = loading;
    assign bus.we_x      = (state == LOAD_X) && bus.ld_valid && !abrt;
    assign bus.we_w      = (state == LOAD_W) && bus.ld_valid && !abrt;
    assign bus.data_in   = bus.ld_data;
    assign bus.address_x = ((state == LOAD_X) || (state == RUN)) ? i : '0;
    assign bus.address_w = ((state == LOAD_W) || (state == RUN)) ? wa : '0;
    assign bus.sel_x     = sel_x;
    assign bus.sel_w     = sel_w;
    assign bus.bit_valid = vld_q;
    assign bus.bit_x     = vld_q & bus.data_out_x;
    assign bus.bit_w     = vld_q & bus.data_out_w;
    assign bus.bit_first = vld_q & first_q;
    assign bus.bit_last  = vld_q & last_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_sys_ctrl.sv
// Randomized + directed bench for mem_sys_ctrl against a transaction-level model and mem_sys stand-in.
module tb_mem_sys_ctrl;
    localparam int XAW = 10;
    localparam int WAW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    mem_sys_ctrl_if #(.XAW(XAW), .WAW(WAW)) bus();

`ifdef MEM_SYS_CTRL_ABORT_EN
    mem_sys_ctrl #(.XAW(XAW), .WAW(WAW)) dut (.clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus));
`else
    mem_sys_ctrl #(.XAW(XAW), .WAW(WAW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int checks = 0;
    int failures = 0;
    longint cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // mem_sys stand-in: one-cycle read latency, contents written only by the DUT
    bit mem_x [int];
    bit mem_w [int];
    bit dox = 1'b0, dow = 1'b0;
    assign bus.data_out_x = dox;
    assign bus.data_out_w = dow;
    always @(posedge clk) begin
        int kx, kw;
        kx = int'(bus.sel_x) * (1 << XAW) + int'(bus.address_x);
        kw = int'(bus.sel_w) * (1 << WAW) + int'(bus.address_w);
        dox <= mem_x.exists(kx) ? mem_x[kx] : 1'b0;
        dow <= mem_w.exists(kw) ? mem_w[kw] : 1'b0;
        if (bus.we_x) mem_x[kx] = bus.data_in;
        if (bus.we_w) mem_w[kw] = bus.data_in;
    end

    // Reference model: what each command must produce, in terms of counts and offsets
    bit ref_x [int];
    bit ref_w [int];
    bit     m_busy = 1'b0;
    int     m_op = 3, m_li = 0, m_lo = 0, m_total = 0, m_cnt = 0;
    int     m_sx = 0, m_sw = 0;
    longint m_start = 0, m_done_at = -1;

    function automatic bit rx(input int bank, input int a);
        int k = bank * (1 << XAW) + a;
        return ref_x.exists(k) ? ref_x[k] : 1'b0;
    endfunction
    function automatic bit rw(input int bank, input int a);
        int k = bank * (1 << WAW) + a;
        return ref_w.exists(k) ? ref_w[k] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done_at = -1; m_sx = 0; m_sw = 0; m_op = 3;
        end else begin
            if (m_busy) begin
                if (abort) m_busy = 1'b0;
                else if (m_op < 2 && bus.ld_valid) begin
                    if (m_op == 0) ref_x[m_sx * (1 << XAW) + m_cnt] = bus.ld_data;
                    else           ref_w[m_sw * (1 << WAW) + m_cnt] = bus.ld_data;
                    m_cnt++;
                    if (m_cnt == m_total) begin m_busy = 1'b0; m_done_at = cyc + 1; end
                end else if (m_op == 2 && cyc - m_start == longint'(m_total)) begin
                    m_busy = 1'b0; m_done_at = cyc + 1;
                end
            end else if (bus.cmd_valid) begin
                m_op = int'(bus.cmd_op); m_sx = int'(bus.cmd_bank_x); m_sw = int'(bus.cmd_bank_w);
                m_li = int'(bus.cmd_len_in); m_lo = int'(bus.cmd_len_out);
                m_start = cyc + 1; m_cnt = 0;
                m_total = (m_op == 0) ? m_li + 1 : (m_li + 1) * (m_lo + 1);
                if (m_op == 3) m_done_at = cyc + 1;
                else m_busy = 1'b1;
            end
            cyc++;
        end
    end

    // Observation bookkeeping for directed literal checks
    logic [3:0] cap [$];
    int wad [$];
    int n_wex = 0, n_wew = 0, n_done = 0;

    task automatic clr();
        cap.delete(); wad.delete(); n_wex = 0; n_wew = 0; n_done = 0;
    endtask

    always @(negedge clk) begin
        longint n;
        int b;
        if (!rst_n) begin
            chk("rst_cmd_ready", bus.cmd_ready, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_ld_ready", bus.ld_ready, 0);
            chk("rst_we", {bus.we_x, bus.we_w}, 0);
            chk("rst_addr_x", bus.address_x, 0);
            chk("rst_addr_w", bus.address_w, 0);
            chk("rst_sel", {bus.sel_x, bus.sel_w}, 0);
            chk("rst_stream", {bus.bit_valid, bus.bit_x, bus.bit_w, bus.bit_first, bus.bit_last}, 0);
            chk("rst_done", bus.done, 0);
        end else begin
            n = cyc - m_start;
            chk("cmd_ready", bus.cmd_ready, !m_busy);
            chk("busy", bus.busy, m_busy);
            chk("ld_ready", bus.ld_ready, m_busy && m_op < 2);
            chk("data_in", bus.data_in, bus.ld_data);
            chk("sel_x", bus.sel_x, m_sx);
            chk("sel_w", bus.sel_w, m_sw);
            chk("done", bus.done, cyc == m_done_at);
            chk("we_x", bus.we_x, m_busy && m_op == 0 && bus.ld_valid && !abort);
            chk("we_w", bus.we_w, m_busy && m_op == 1 && bus.ld_valid && !abort);
            if (m_busy && m_op == 0 && bus.ld_valid) chk("load_addr_x", bus.address_x, m_cnt);
            if (m_busy && m_op == 1 && bus.ld_valid) chk("load_addr_w", bus.address_w, m_cnt);
            if (m_busy && m_op == 2 && n < longint'(m_total)) begin
                chk("run_addr_x", bus.address_x, n % (m_li + 1));
                chk("run_addr_w", bus.address_w, n);
            end
            chk("bit_valid", bus.bit_valid, m_busy && m_op == 2 && n >= 1);
            if (m_busy && m_op == 2 && n >= 1) begin
                b = int'(n - 1);
                chk("bit_x", bus.bit_x, rx(m_sx, b % (m_li + 1)));
                chk("bit_w", bus.bit_w, rw(m_sw, b));
                chk("bit_first", bus.bit_first, (b % (m_li + 1)) == 0);
                chk("bit_last", bus.bit_last, (b % (m_li + 1)) == m_li);
            end
            if (bus.bit_valid) cap.push_back({bus.bit_first, bus.bit_last, bus.bit_x, bus.bit_w});
            if (bus.we_x) begin n_wex++; wad.push_back(int'(bus.address_x)); end
            if (bus.we_w) begin n_wew++; wad.push_back(int'(bus.address_w)); end
            if (bus.done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] bx, input logic [1:0] bw,
                        input int li, input int lo);
        int t = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_bank_x = bx; bus.cmd_bank_w = bw;
        bus.cmd_len_in = XAW'(li); bus.cmd_len_out = (WAW-XAW)'(lo);
        while (!bus.cmd_ready && t < 500) begin tick(); t++; end
        if (!bus.cmd_ready) chk("cmd_timeout", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load_bits(input bit bits [$], input int gap_at, input bit rnd_gaps);
        int t;
        foreach (bits[k]) begin
            if (k == gap_at || (rnd_gaps && $urandom_range(0, 3) == 0)) begin
                bus.ld_valid = 1'b0; bus.ld_data = 1'($urandom); tick();
            end
            bus.ld_valid = 1'b1; bus.ld_data = bits[k];
            t = 0;
            while (!bus.ld_ready && t < 100) begin tick(); t++; end
            if (!bus.ld_ready) chk("ld_timeout", bus.ld_ready, 1);
            tick();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 4000) begin
            bus.ld_valid = 1'($urandom); bus.ld_data = 1'($urandom);
            tick(); t++;
        end
        bus.ld_valid = 1'b0;
        if (bus.busy) chk("idle_timeout", bus.busy, 0);
        tick();
    endtask

    task automatic check_run(input string tag);
        logic [7:0] xs = '0, ws = '0, fs = '0, ls = '0;
        chk({tag, "_count"}, cap.size(), 8);
        foreach (cap[k]) if (k < 8) begin
            fs[k] = cap[k][3]; ls[k] = cap[k][2]; xs[k] = cap[k][1]; ws[k] = cap[k][0];
        end
        chk({tag, "_bit_x"}, xs, 8'b1101_1101);
        chk({tag, "_bit_w"}, ws, 8'b0101_0011);
        chk({tag, "_first"}, fs, 8'b0001_0001);
        chk({tag, "_last"}, ls, 8'b1000_1000);
        chk({tag, "_done"}, n_done, 1);
    endtask

    initial begin
        bit xb [$];
        bit wb [$];
        bit rb [$];
        int li, lo, op, tot;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b11; bus.cmd_bank_x = '0; bus.cmd_bank_w = '0;
        bus.cmd_len_in = '0; bus.cmd_len_out = '0; bus.ld_valid = 1'b0; bus.ld_data = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ready", bus.cmd_ready, 1);
        chk("idle_busy", bus.busy, 0);

        // LOAD_X: bank 2, four bits with one gap before the third
        clr();
        xb = '{1'b1, 1'b0, 1'b1, 1'b1};
        send(2'b00, 2'd2, 2'd0, 3, 0);
        load_bits(xb, 2, 1'b0);
        tick();
        chk("ldx_writes", n_wex, 4);
        foreach (wad[k]) chk("ldx_addr", wad[k], k);
        chk("ldx_sel", bus.sel_x, 2);
        chk("ldx_done", n_done, 1);

        // LOAD_W: 4 inputs x 2 neurons into bank 1
        clr();
        wb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        send(2'b01, 2'd2, 2'd1, 3, 1);
        load_bits(wb, -1, 1'b1);
        tick();
        chk("ldw_writes", n_wew, 8);
        chk("ldw_we_x", n_wex, 0);
        foreach (wad[k]) chk("ldw_addr", wad[k], k);

        // RUN with a command attempted while busy
        clr();
        send(2'b10, 2'd2, 2'd1, 3, 1);
        tick(); tick();
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11;
        chk("busy_ready", bus.cmd_ready, 0);
        tick(); tick();
        bus.cmd_valid = 1'b0;
        wait_idle();
        check_run("run1");

        // Reset mid-RUN, then a full RUN again
        clr();
        send(2'b10, 2'd2, 2'd1, 3, 1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_done", n_done, 0);
        chk("rst_sel_cleared", {bus.sel_x, bus.sel_w}, 0);
        clr();
        send(2'b10, 2'd2, 2'd1, 3, 1);
        wait_idle();
        check_run("run2");

`ifdef MEM_SYS_CTRL_ABORT_EN
        clr();
        send(2'b01, 2'd0, 2'd3, 3, 1);
        bus.ld_valid = 1'b1; bus.ld_data = 1'b1; tick(); tick();
        abort = 1'b1; tick();
        abort = 1'b0; bus.ld_valid = 1'b0;
        chk("abort_idle", bus.busy, 0);
        tick(); tick();
        chk("abort_writes", n_wew, 2);
        chk("abort_no_done", n_done, 0);
`endif

        // Random commands on small shapes
        for (int r = 0; r < 40; r++) begin
            op = $urandom_range(0, 3);
            li = $urandom_range(0, 5);
            lo = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) tick();
            send(2'(op), 2'($urandom), 2'($urandom), li, lo);
            if (op < 2) begin
                tot = (op == 0) ? li + 1 : (li + 1) * (lo + 1);
                rb.delete();
                for (int k = 0; k < tot; k++) rb.push_back(1'($urandom));
                load_bits(rb, -1, 1'b1);
            end
            wait_idle();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
